mouse_click_tracker: RTL and testbench
======================================

Name: mouse_click_tracker

Overview:
- Parametrised successor to the mouse top: consumes already-synchronised mouse position and button levels in a single clock domain.
- Debounces N buttons and maps the pointer to Minesweeper grid cells using a shift-based mapping.
- Classifies press, release and double-click events, and queues them in a small FIFO with a valid/ready handshake for game logic.
- Sits between the mouse CDC stage and the board controller.

Parameters:
- XW, 12, pointer x width
- YW, 12, pointer y width
- N_BTN, 2, button channels (0=left, 1=right, 2=middle)
- DEBOUNCE_CYC, 100000, consecutive differing samples needed to flip a debounced level (≥1)
- DBL_CLICK_CYC, 25000000, double-click window in cycles, measured from release
- GRID_X0, 0, grid left pixel
- GRID_Y0, 0, grid top pixel
- CELL_LOG2, 5, log2 of cell size in pixels
- GRID_COLS, 16, columns
- GRID_ROWS, 16, rows
- FIFO_DEPTH, 4, event FIFO depth (power of 2, ≥2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- xpos  in  XW  pointer x
- ypos  in  YW  pointer y
- btn  in  N_BTN  raw button levels
- btn_level  out  N_BTN  debounced levels
- cur_col  out  COL_W  cell column under pointer; COL_W=max(1,$clog2(GRID_COLS))
- cur_row  out  ROW_W  cell row under pointer
- cur_in_grid  out  1  pointer inside grid
- ev_valid  out  1  FIFO head valid
- ev_ready  in  1  consumer accepts head
- ev_btn  out  BTN_W  button index of head event
- ev_type  out  2  event type (mouse_pkg::ev_type_t)
- ev_col  out  COL_W  cell column captured at the event
- ev_row  out  ROW_W  cell row captured at the event
- ev_in_grid  out  1  pointer inside grid at the event
- overflow  out  1  sticky flag: an event was dropped

Behaviour:
- Reset: all outputs 0, debounce counters 0, double-click windows disarmed, FIFO empty.
- Input register: xpos, ypos and btn are registered once.
- Grid mapping, registered:
  - dx = x − GRID_X0 and dy = y − GRID_Y0, computed one bit wider than the input.
  - col = dx >> CELL_LOG2; row = dy >> CELL_LOG2.
  - in_grid = (x ≥ GRID_X0) && (y ≥ GRID_Y0) && (col < GRID_COLS) && (row < GRID_ROWS).
  - When not in_grid, col and row are forced to 0.
  - Latency: 2 cycles from xpos/ypos to cur_*.
- Debounce, per channel:
  - The counter increments while the registered btn differs from btn_level and clears when they match.
  - When DEBOUNCE_CYC differing samples have been seen, btn_level toggles on the next edge and the counter clears.
- Edge classification:
  - Debounced rise gives PRESS. It gives DOUBLE instead when that channel's window is armed and its counter < DBL_CLICK_CYC; DOUBLE disarms the window.
  - Debounced fall gives RELEASE and arms the window, with the counter at 0.
  - The window counter saturates at DBL_CLICK_CYC and disarms when it reaches it.
  - An edge snapshots the current cur_col, cur_row and cur_in_grid.
- Arbitration:
  - Each channel has a one-entry pending slot.
  - One push per cycle, lowest index first.
  - A new edge on a channel whose slot is still pending overwrites it and sets overflow.
- FIFO:
  - Push happens the cycle after the edge; ev_valid rises the following cycle. With an empty FIFO and no contention, that is 2 cycles after btn_level changes.
  - Pop when ev_valid && ev_ready.
  - Push and pop in the same cycle is allowed when full.
  - A push while full (no pop) drops the event and sets overflow.
  - Outputs are stable while ev_valid && !ev_ready.
- overflow clears only on reset.
- Reset asserted mid-operation: immediate return to the reset state; pending and queued events are lost.

Optional Feature:
- Macro: MOUSE_DBL_CLICK_EN.
- Defined: DOUBLE classification as described above.
- Undefined:
  - Window logic is absent; every rise gives PRESS.
  - DBL_CLICK_CYC is ignored.
  - The DOUBLE encoding is never produced.

Decomposition:
- Package mouse_pkg holds:
  - ev_type_t enum: EV_NONE=0, EV_PRESS=1, EV_RELEASE=2, EV_DOUBLE=3.
  - mouse_event_t struct: btn, type, col, row, in_grid. The FIFO stores this struct.
  - Helper function clog2_min1.
- Sub-module mouse_btn_debounce: one channel covering debounce, edge detect and the double-click window, instantiated N_BTN times.
- The FIFO is inline.

Test Plan (DEBOUNCE_CYC=4, DBL_CLICK_CYC=20, GRID_X0=100, GRID_Y0=50, CELL_LOG2=5, GRID_COLS=8, GRID_ROWS=8, FIFO_DEPTH=4):
- Mapping: xpos=163, ypos=50 → cur_col=1, cur_row=0, cur_in_grid=1 after 2 cycles. xpos=99 → cur_in_grid=0, col=0. xpos=356 → col 8 ≥ 8, cur_in_grid=0.
- Debounce: btn[0] glitch high for 3 cycles → no level change, no event. btn[0] held high for 4 cycles → btn_level[0] rises. ev_valid rises 2 cycles later with ev_type=PRESS, ev_btn=0.
- Double click: press, release, then press 10 cycles after the release's debounced fall → third event DOUBLE. Repeat with a 25-cycle gap → PRESS. With the macro undefined, both give PRESS.
- Simultaneous edges: btn=2'b11 stable → PRESS btn0 popped first, then PRESS btn1, both with identical ev_col/ev_row.
- Backpressure/overflow: ev_ready=0, generate 5 events → 4 queued, overflow=1. Then ev_ready=1 → 4 pops in order, ev_valid falls, overflow stays 1 until rst_n=0.
- Reset mid-debounce: rst_n pulsed low at count 2 → all outputs 0. After release of reset, a full 4-cycle stable period is required for the level to flip.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared types for the mouse click tracker: event encoding, the queued event record
// and a width helper.
package mouse_pkg;

    typedef enum logic [1:0] {
        EV_NONE    = 2'd0,
        EV_PRESS   = 2'd1,
        EV_RELEASE = 2'd2,
        EV_DOUBLE  = 2'd3
    } ev_type_t;

    // Event fields are sized for the largest supported configuration; the top slices them down.
    localparam int EV_BTN_MAX_W  = 4;
    localparam int EV_CELL_MAX_W = 12;

    typedef struct packed {
        logic [EV_BTN_MAX_W-1:0]  btn;
        ev_type_t                 ev_type;
        logic [EV_CELL_MAX_W-1:0] col;
        logic [EV_CELL_MAX_W-1:0] row;
        logic                     in_grid;
    } mouse_event_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mouse_btn_debounce.sv
// One button channel: debounce, edge classification and (with MOUSE_DBL_CLICK_EN)
// the double-click window measured from the debounced release.
module mouse_btn_debounce
    import mouse_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = 100000,
    parameter int DBL_CLICK_CYC = 25000000
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     btn_sync,
    output logic     level,
    output logic     edge_fire,
    output ev_type_t edge_type
);

    localparam int DB_W = clog2_min1(DEBOUNCE_CYC);

    logic [DB_W-1:0] db_cnt;
    logic            flip_now;
    logic            rise_now;
    logic            fall_now;
    logic            dbl_hit;

    // The sample that completes DEBOUNCE_CYC differing samples flips the level on this edge.
    assign flip_now = (btn_sync != level) && (db_cnt == DB_W'(DEBOUNCE_CYC - 1));
    assign rise_now = flip_now && btn_sync;
    assign fall_now = flip_now && !btn_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level     <= 1'b0;
            db_cnt    <= '0;
            edge_fire <= 1'b0;
            edge_type <= EV_NONE;
        end else begin
            edge_fire <= rise_now || fall_now;
            if (rise_now) begin
                edge_type <= dbl_hit ? EV_DOUBLE : EV_PRESS;
            end else if (fall_now) begin
                edge_type <= EV_RELEASE;
            end
            if (btn_sync == level) begin
                db_cnt <= '0;
            end else if (flip_now) begin
                level  <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

`ifdef MOUSE_DBL_CLICK_EN
    localparam int WIN_W = $clog2(DBL_CLICK_CYC + 1);

    logic             armed;
    logic [WIN_W-1:0] win_cnt;

    assign dbl_hit = armed && (win_cnt < WIN_W'(DBL_CLICK_CYC));

    // Counter only runs while armed and disarms on reaching the limit, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            win_cnt <= '0;
        end else if (fall_now) begin
            armed   <= 1'b1;
            win_cnt <= '0;
        end else if (rise_now) begin
            armed   <= 1'b0;
        end else if (armed) begin
            win_cnt <= win_cnt + WIN_W'(1);
            if (win_cnt == WIN_W'(DBL_CLICK_CYC - 1)) begin
                armed <= 1'b0;
            end
        end
    end
`else
    localparam int unused_dbl_click_cyc = DBL_CLICK_CYC;
    assign dbl_hit = 1'b0;
`endif

endmodule

// File: rtl/mouse_click_tracker.sv
// Mouse click tracker: registered pointer-to-cell mapping, per-button debounce and a small
// event FIFO. Define MOUSE_DBL_CLICK_EN to classify quick re-presses as EV_DOUBLE.
module mouse_click_tracker
    import mouse_pkg::*;
#(
    parameter int XW            = 12,
    parameter int YW            = 12,
    parameter int N_BTN         = 2,
    parameter int DEBOUNCE_CYC  = 100000,
    parameter int DBL_CLICK_CYC = 25000000,
    parameter int GRID_X0       = 0,
    parameter int GRID_Y0       = 0,
    parameter int CELL_LOG2     = 5,
    parameter int GRID_COLS     = 16,
    parameter int GRID_ROWS     = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [XW-1:0]                       xpos,
    input  logic [YW-1:0]                       ypos,
    input  logic [N_BTN-1:0]                    btn,
    output logic [N_BTN-1:0]                    btn_level,
    output logic [clog2_min1(GRID_COLS)-1:0]    cur_col,
    output logic [clog2_min1(GRID_ROWS)-1:0]    cur_row,
    output logic                                cur_in_grid,
    output logic                                ev_valid,
    input  logic                                ev_ready,
    output logic [clog2_min1(N_BTN)-1:0]        ev_btn,
    output ev_type_t                            ev_type,
    output logic [clog2_min1(GRID_COLS)-1:0]    ev_col,
    output logic [clog2_min1(GRID_ROWS)-1:0]    ev_row,
    output logic                                ev_in_grid,
    output logic                                overflow
);

    localparam int COL_W = clog2_min1(GRID_COLS);
    localparam int ROW_W = clog2_min1(GRID_ROWS);
    localparam int BTN_W = clog2_min1(N_BTN);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [XW-1:0]    x_r;
    logic [YW-1:0]    y_r;
    logic [N_BTN-1:0] btn_r;
    logic [XW:0]      dx, col_full;
    logic [YW:0]      dy, row_full;
    logic             map_in;

    // A borrow out of the widened subtraction marks a pointer left of / above the grid.
    assign dx       = {1'b0, x_r} - (XW+1)'(GRID_X0);
    assign dy       = {1'b0, y_r} - (YW+1)'(GRID_Y0);
    assign col_full = dx >> CELL_LOG2;
    assign row_full = dy >> CELL_LOG2;
    assign map_in   = !dx[XW] && !dy[YW] &&
                      (col_full < (XW+1)'(GRID_COLS)) && (row_full < (YW+1)'(GRID_ROWS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r         <= '0;
            y_r         <= '0;
            btn_r       <= '0;
            cur_col     <= '0;
            cur_row     <= '0;
            cur_in_grid <= 1'b0;
        end else begin
            x_r         <= xpos;
            y_r         <= ypos;
            btn_r       <= btn;
            cur_col     <= map_in ? col_full[COL_W-1:0] : '0;
            cur_row     <= map_in ? row_full[ROW_W-1:0] : '0;
            cur_in_grid <= map_in;
        end
    end

    logic [N_BTN-1:0] fire;
    ev_type_t         fire_type [N_BTN];

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        mouse_btn_debounce #(
            .DEBOUNCE_CYC  (DEBOUNCE_CYC),
            .DBL_CLICK_CYC (DBL_CLICK_CYC)
        ) u_debounce (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_sync  (btn_r[g]),
            .level     (btn_level[g]),
            .edge_fire (fire[g]),
            .edge_type (fire_type[g])
        );
    end

    logic [N_BTN-1:0] pend_v;
    mouse_event_t     pend_ev [N_BTN];
    logic [N_BTN-1:0] grant;
    logic [BTN_W-1:0] sel;
    logic             push_v;
    logic             ovf_hit;

    // Fixed priority: scanning downward leaves the lowest pending index granted.
    always_comb begin
        sel    = '0;
        push_v = 1'b0;
        grant  = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend_v[i]) begin
                sel    = BTN_W'(i);
                push_v = 1'b1;
                grant  = '0;
                grant[i] = 1'b1;
            end
        end
    end

    assign ovf_hit = |(fire & pend_v & ~grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v <= '0;
            for (int i = 0; i < N_BTN; i++) pend_ev[i] <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (fire[i]) begin
                    pend_v[i]  <= 1'b1;
                    pend_ev[i] <= '{btn:     EV_BTN_MAX_W'(i),
                                    ev_type: fire_type[i],
                                    col:     EV_CELL_MAX_W'(cur_col),
                                    row:     EV_CELL_MAX_W'(cur_row),
                                    in_grid: cur_in_grid};
                end else if (grant[i]) begin
                    pend_v[i] <= 1'b0;
                end
            end
        end
    end

    // Handshake: ev_valid flags a queued head; it leaves on any clock edge where
    // ev_valid && ev_ready, and the head fields are held while ev_valid && !ev_ready.
    mouse_event_t     mem [FIFO_DEPTH];
    mouse_event_t     head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             pop, full, push_ok, drop;
    logic             unused_head;

    assign pop     = ev_valid && ev_ready;
    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign push_ok = push_v && (!full || pop);
    assign drop    = push_v && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= pend_ev[sel];
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
            if (drop || ovf_hit) overflow <= 1'b1;
        end
    end

    assign head        = mem[rd_ptr];
    assign unused_head = ^head;
    assign ev_valid    = (count != '0);
    assign ev_btn      = head.btn[BTN_W-1:0];
    assign ev_type     = head.ev_type;
    assign ev_col      = head.col[COL_W-1:0];
    assign ev_row      = head.row[ROW_W-1:0];
    assign ev_in_grid  = head.in_grid;

endmodule

// File: tb/tb_mouse_click_tracker.sv
// Bench for mouse_click_tracker: randomized pointer/button stimulus checked against a
// behavioural event model (cell arithmetic, click timing measured in stimulus cycles).
module tb_mouse_click_tracker;
    import mouse_pkg::*;

    localparam int XW = 12, YW = 12, N_BTN = 2;
    localparam int DEB = 4, DBL = 20;
    localparam int X0 = 100, Y0 = 50, CELL = 32, COLS = 8, ROWS = 8, DEPTH = 4;
    localparam int COL_W = 3, ROW_W = 3, BTN_W = 1;
    localparam int EW = BTN_W + 2 + COL_W + ROW_W + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [XW-1:0]    xpos = '0;
    logic [YW-1:0]    ypos = '0;
    logic [N_BTN-1:0] btn = '0;
    logic             ev_ready = 1'b0;
    logic [N_BTN-1:0] btn_level;
    logic [COL_W-1:0] cur_col, ev_col;
    logic [ROW_W-1:0] cur_row, ev_row;
    logic             cur_in_grid, ev_valid, ev_in_grid, overflow;
    logic [BTN_W-1:0] ev_btn;
    ev_type_t         ev_type;

    mouse_click_tracker #(
        .XW(XW), .YW(YW), .N_BTN(N_BTN), .DEBOUNCE_CYC(DEB), .DBL_CLICK_CYC(DBL),
        .GRID_X0(X0), .GRID_Y0(Y0), .CELL_LOG2(5), .GRID_COLS(COLS), .GRID_ROWS(ROWS),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos), .btn(btn),
        .btn_level(btn_level), .cur_col(cur_col), .cur_row(cur_row), .cur_in_grid(cur_in_grid),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_btn(ev_btn), .ev_type(ev_type),
        .ev_col(ev_col), .ev_row(ev_row), .ev_in_grid(ev_in_grid), .overflow(overflow)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and reference model state
    logic [EW-1:0]    exp_q[$];
    int               n_checks = 0;
    int               n_pass = 0;
    int               m_x = 0, m_y = 0;
    logic [N_BTN-1:0] m_btn = '0;
    bit               m_armed [N_BTN];
    int               m_fall_t [N_BTN];

    function automatic logic [COL_W+ROW_W:0] cell_of(input int x, input int y);
        int c, r;
        if (x < X0 || y < Y0) return '0;
        c = (x - X0) / CELL;
        r = (y - Y0) / CELL;
        if (c >= COLS || r >= ROWS) return '0;
        return {COL_W'(c), ROW_W'(r), 1'b1};
    endfunction

    function automatic logic [COL_W+ROW_W:0] cur_cell();
        return {cur_col, cur_row, cur_in_grid};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_btn = '0;
        for (int i = 0; i < N_BTN; i++) begin
            m_armed[i]  = 1'b0;
            m_fall_t[i] = 0;
        end
    endtask

    // Driver tasks: called right after a negedge
    task automatic set_pos(input int x, input int y);
        m_x  = x;
        m_y  = y;
        xpos = XW'(x);
        ypos = YW'(y);
    endtask

    // A held level change becomes one event; rise within DBL cycles of the last release is a double.
    task automatic set_btn(input logic [N_BTN-1:0] v);
        logic [1:0] t;
        bit         quick;
        for (int i = 0; i < N_BTN; i++) begin
            if (v[i] != m_btn[i]) begin
                if (v[i]) begin
                    quick = m_armed[i] && ((cyc - m_fall_t[i]) <= DBL);
                    t = 2'd1;
`ifdef MOUSE_DBL_CLICK_EN
                    if (quick) t = 2'd3;
`endif
                    m_armed[i] = 1'b0;
                end else begin
                    t = 2'd2;
                    m_armed[i]  = 1'b1;
                    m_fall_t[i] = cyc;
                end
                exp_q.push_back({BTN_W'(i), t, cell_of(m_x, m_y)});
            end
        end
        m_btn = v;
        btn   = v;
    endtask

    task automatic pop_event(output bit got, output logic [EW-1:0] obs);
        int waited = 0;
        got = 1'b0;
        obs = '0;
        while (ev_valid !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (ev_valid === 1'b1) begin
            got = 1'b1;
            obs = {ev_btn, ev_type, ev_col, ev_row, ev_in_grid};
            ev_ready = 1'b1;
            @(negedge clk);
            ev_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_pos(0, 0);
        btn = '0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (btn_level === '0 && ev_valid === 1'b0 && overflow === 1'b0) n_pass++;
        else $display("FAIL reset_flags: level=%b valid=%b ovf=%b, required 00 0 0", btn_level, ev_valid, overflow);
        n_checks++;
        if (cur_cell() === '0) n_pass++;
        else $display("FAIL reset_cur: cur=%h, required 0", cur_cell());
        n_checks++;
        if ({ev_btn, ev_type, ev_col, ev_row, ev_in_grid} === '0) n_pass++;
        else $display("FAIL reset_head: head=%h, required 0", {ev_btn, ev_type, ev_col, ev_row, ev_in_grid});
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (btn_level === '0 && ev_valid === 1'b0 && overflow === 1'b0 && cur_in_grid === 1'b0) n_pass++;
        else $display("FAIL reset_after: level=%b valid=%b ovf=%b in_grid=%b, required all 0",
                      btn_level, ev_valid, overflow, cur_in_grid);
    endtask

    task automatic test_mapping();
        int xs[8] = '{163, 99, 356, 355, 100, 100, 100, 250};
        int ys[8] = '{50, 50, 50, 50, 305, 306, 49, 120};
        logic [COL_W+ROW_W:0] prev_exp, want;
        prev_exp = cell_of(m_x, m_y);
        for (int i = 0; i < 14; i++) begin
            if (i < 8) set_pos(xs[i], ys[i]);
            else       set_pos($urandom_range(60, 420), $urandom_range(20, 360));
            @(negedge clk);
            n_checks++;
            if (cur_cell() === prev_exp) n_pass++;
            else $display("FAIL map_latency_%0d: cur=%h after 1 cycle, required %h", i, cur_cell(), prev_exp);
            @(negedge clk);
            want = cell_of(m_x, m_y);
            n_checks++;
            if (cur_cell() === want) n_pass++;
            else $display("FAIL map_%0d: x=%0d y=%0d cur=%h, required %h", i, m_x, m_y, cur_cell(), want);
            prev_exp = want;
        end
    endtask

    task automatic test_debounce();
        bit got;
        logic [EW-1:0] obs;
        set_pos(163, 50);
        repeat (30) @(negedge clk);
        btn = 2'b01;
        repeat (3) @(negedge clk);
        btn = 2'b00;
        repeat (10) @(negedge clk);
        n_checks++;
        if (btn_level === 2'b00 && ev_valid === 1'b0) n_pass++;
        else $display("FAIL glitch: level=%b valid=%b, required 00 0", btn_level, ev_valid);
        set_btn(2'b01);
        repeat (4) @(negedge clk);
        n_checks++;
        if (btn_level === 2'b00) n_pass++;
        else $display("FAIL db_early: level=%b, required 00", btn_level);
        @(negedge clk);
        n_checks++;
        if (btn_level === 2'b01) n_pass++;
        else $display("FAIL db_rise: level=%b, required 01", btn_level);
        @(negedge clk);
        n_checks++;
        if (ev_valid === 1'b0) n_pass++;
        else $display("FAIL ev_early: valid=%b, required 0", ev_valid);
        @(negedge clk);
        n_checks++;
        if (ev_valid === 1'b1) n_pass++;
        else $display("FAIL ev_rise: valid=%b, required 1", ev_valid);
        set_btn(2'b00);
        while (exp_q.size() > 0) begin
            pop_event(got, obs);
            n_checks++;
            if (got && obs === exp_q[0]) n_pass++;
            else $display("FAIL db_event: got=%0b event=%h, required %h", got, obs, exp_q[0]);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_double_click();
        bit got;
        logic [EW-1:0] obs;
        logic [N_BTN-1:0] v;
        int ch, gap, t_rel;
        set_pos(260, 200);
        repeat (30) @(negedge clk);
        for (int it = 0; it < 6; it++) begin
            ch  = (it < 2) ? 0 : $urandom_range(0, N_BTN - 1);
            gap = (it == 0) ? 10 : (it == 1) ? 25 :
                  ($urandom_range(0, 1) ? $urandom_range(10, 16) : $urandom_range(26, 34));
            v = '0;
            v[ch] = 1'b1;
            set_btn(v);
            repeat (8) @(negedge clk);
            set_btn('0);
            t_rel = cyc;
            while (cyc < t_rel + gap) @(negedge clk);
            set_btn(v);
            repeat (8) @(negedge clk);
            set_btn('0);
            repeat (8) @(negedge clk);
            while (exp_q.size() > 0) begin
                pop_event(got, obs);
                n_checks++;
                if (got && obs === exp_q[0]) n_pass++;
                else $display("FAIL dbl_event_%0d: gap=%0d got=%0b event=%h, required %h", it, gap, got, obs, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_simultaneous();
        bit got;
        logic [EW-1:0] obs;
        set_pos(200, 120);
        repeat (30) @(negedge clk);
        for (int phase = 0; phase < 2; phase++) begin
            set_btn(phase == 0 ? 2'b11 : 2'b00);
            while (exp_q.size() > 0) begin
                pop_event(got, obs);
                n_checks++;
                if (got && obs === exp_q[0]) n_pass++;
                else $display("FAIL simul_event: got=%0b event=%h, required %h", got, obs, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (ev_valid === 1'b0) n_pass++;
        else $display("FAIL simul_empty: valid=%b, required 0", ev_valid);
    endtask

    task automatic test_back_to_back();
        bit got;
        logic [EW-1:0] obs;
        set_pos($urandom_range(100, 355), $urandom_range(50, 305));
        repeat (30) @(negedge clk);
        ev_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_btn((k % 2 == 0) ? 2'b01 : 2'b00);
            repeat (8) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        void'(exp_q.pop_back());
        n_checks++;
        if (overflow === 1'b1 && ev_valid === 1'b1) n_pass++;
        else $display("FAIL full_flags: ovf=%b valid=%b, required 1 1", overflow, ev_valid);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({ev_btn, ev_type, ev_col, ev_row, ev_in_grid} === exp_q[0]) n_pass++;
            else $display("FAIL stall_head_%0d: head=%h, required %h", k,
                          {ev_btn, ev_type, ev_col, ev_row, ev_in_grid}, exp_q[0]);
            repeat (3) @(negedge clk);
        end
        while (exp_q.size() > 0) begin
            pop_event(got, obs);
            n_checks++;
            if (got && obs === exp_q[0]) n_pass++;
            else $display("FAIL b2b_event: got=%0b event=%h, required %h", got, obs, exp_q[0]);
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        n_checks++;
        if (ev_valid === 1'b0 && overflow === 1'b1) n_pass++;
        else $display("FAIL drained: valid=%b ovf=%b, required 0 1", ev_valid, overflow);
        set_btn(2'b00);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (overflow === 1'b0 && ev_valid === 1'b0) n_pass++;
        else $display("FAIL ovf_reset: ovf=%b valid=%b, required 0 0", overflow, ev_valid);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_debounce();
        bit got;
        logic [EW-1:0] obs;
        set_pos(163, 50);
        repeat (5) @(negedge clk);
        set_btn(2'b10);
        repeat (10) @(negedge clk);
        btn = 2'b11;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (btn_level === 2'b00 && ev_valid === 1'b0 && overflow === 1'b0 && cur_cell() === '0) n_pass++;
        else $display("FAIL mid_reset: level=%b valid=%b ovf=%b cur=%h, required all 0",
                      btn_level, ev_valid, overflow, cur_cell());
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_btn(2'b11);
        repeat (4) @(negedge clk);
        n_checks++;
        if (btn_level === 2'b00) n_pass++;
        else $display("FAIL mid_early: level=%b, required 00", btn_level);
        @(negedge clk);
        n_checks++;
        if (btn_level === 2'b11) n_pass++;
        else $display("FAIL mid_rise: level=%b, required 11", btn_level);
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) set_btn(2'b00);
            while (exp_q.size() > 0) begin
                pop_event(got, obs);
                n_checks++;
                if (got && obs === exp_q[0]) n_pass++;
                else $display("FAIL mid_event: got=%0b event=%h, required %h", got, obs, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    endtask

    initial begin
        test_reset();
        test_mapping();
        test_debounce();
        test_double_click();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_debounce();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
